mmm_edge_feeder: RTL and testbench
==================================

// Module: mmm_edge_feeder
// PURPOSE
//  Transmit side of the processing-element edge interface for the matrix-multiply array.
//  Holds operand matrices A and B in FP16 form. On start, it drives the left edge with the
//  skewed rows of A and the top edge with the skewed columns of B.
//  Generates the pe_we/pe_mux control that each proc_elem expects. Pulses done when the
//  last operand has entered the array.
// PARAMETERS
//  N   4   array dimension; A, B are NxN, one FP16 lane per array row/column
//  DW  16  operand width (IEEE half precision: sign, 5b exponent, 10b fraction)
// PORTS
//  clk       in   1      clock, all logic on rising edge
//  reset     in   1      synchronous, active-high
//  wr_en     in   1      write one operand into the bank selected by wr_sel
//  wr_sel    in   1      0 = bank A, 1 = bank B
//  wr_row    in   IW     row index, IW = $clog2(N)
//  wr_col    in   IW     column index
//  wr_data   in   DW     FP16 operand
//  start     in   1      request one streaming pass
//  busy      out  1      high from the cycle after start is accepted until done
//  done      out  1      one-cycle pulse at the end of a pass
//  left_out  out  N*DW   lane i (bits i*DW +: DW) feeds the left port of array row i
//  top_out   out  N*DW   lane j feeds the top port of array column j
//  pe_we     out  1      broadcast to all PEs; 1 = clear/load the accumulator
//  pe_mux    out  1      broadcast; 1 = accumulate the product into the PE
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, done=0, pe_we=0, pe_mux=0, all lanes 16'h0000, both banks zeroed.
//  - All outputs are registered. No output has a combinational path from any input.
//  - FSM IDLE -> CLEAR -> STREAM -> DONE -> IDLE.
//    IDLE: lanes 0, controls 0. start=1 moves to CLEAR on the next edge.
//    CLEAR (1 cycle): pe_we=1, pe_mux=0, lanes 0, busy=1.
//    STREAM (3N-2 cycles, counter k=0..3N-3): pe_we=0, pe_mux=1, busy=1.
//      left lane i = A[i][k-i] when 0 <= k-i < N, else 16'h0000.
//      top lane j = B[k-j][j] when 0 <= k-j < N, else 16'h0000.
//    DONE (1 cycle): done=1, busy=0, lanes 0, pe_mux=0. Then IDLE.
//  - Latency: start sampled at edge e; CLEAR occupies cycle e+1; k=0 in cycle e+2.
//    done is high in cycle e+3N.
//  - The counter k is IW+2 bits wide and does not wrap. Exit from STREAM occurs at k==3N-3.
//  - start is accepted in IDLE only. start in CLEAR, STREAM or DONE is ignored (not queued).
//  - wr_en is honoured in IDLE only; writes in other states are dropped.
//    Out-of-range indices (>= N) are dropped.
//  - wr_en and start in the same IDLE cycle: the write commits at that edge, and the pass
//    streams the new value.
//  - reset in any state, including mid-STREAM, returns to IDLE on the next edge with
//    outputs zeroed. No done pulse is issued for the aborted pass.
//  - Operands pass through unmodified. No FP arithmetic occurs in this block. Zero padding is +0.0.
// STRUCTURE
//  - mmm_pkg: FP16 field widths, FP16_ZERO=16'h0000, state enum
//    (IDLE/CLEAR/STREAM/DONE), and an index-width function.
//  - Sub-module mmm_skew_bank: an NxN register file with one write port and N-lane
//    diagonal read at skew k. Parameter COL_MAJOR selects A-style (row i, col k-i) or
//    B-style (row k-j, col j) addressing. Instantiated twice.
//  - Top level: FSM, counter k, control/output registers.
// TESTING (N=4)
//  1. reset held 3 cycles -> busy=0, done=0, pe_we=0, pe_mux=0, left_out=top_out=0.
//  2. A[0][0]=16'h4500 (5.0), A[1][0]=16'h4000 (2.0), B[0][0]=16'h4400 (4.0); start
//     -> cycle+1 pe_we=1; k=0 left lane0=4500, top lane0=4400, other lanes 0;
//     k=1 left lane1=4000, left lane0=A[0][1]; done in cycle+12.
//  3. start and wr_en (A[3][3]=16'hC700, -7.0) in the same IDLE cycle
//     -> at k=6 left lane3=C700. start at k=2 -> ignored, exactly one done.
//  4. wr_en during STREAM (A[0][0]=16'h3C00) -> dropped; the next pass k=0 still
//     shows 4500.
//  5. reset asserted at k=3 -> next cycle IDLE, lanes 0, busy=0, no done.
//     All bank entries read 0 on a subsequent pass.
//  6. start held high through DONE -> ignored in DONE; accepted in the following IDLE
//     cycle; second done 3N cycles after acceptance.

Source files
------------

// File: rtl/mmm_pkg.sv
// Shared definitions for the matrix-multiply edge feeder: FP16 layout, FSM states
// and index helpers.
package mmm_pkg;

  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int FP16_W      = 1 + FP16_EXP_W + FP16_FRAC_W;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Index width for an N-entry dimension; a single entry still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction

endpackage

// File: rtl/mmm_skew_bank.sv
// NxN operand register file with one write port and an N-lane diagonal read at skew k.
// COL_MAJOR=0 reads lane l from (row l, col k-l); COL_MAJOR=1 from (row k-l, col l).
module mmm_skew_bank
  import mmm_pkg::*;
#(
  parameter int N         = 4,
  parameter int DW        = FP16_W,
  parameter bit COL_MAJOR = 1'b0,
  localparam int IW       = idx_width(N),
  localparam int KW       = IW + 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we_i,
  input  logic [IW-1:0]   row_i,
  input  logic [IW-1:0]   col_i,
  input  logic [DW-1:0]   data_i,
  input  logic [KW-1:0]   k_i,
  output logic [N*DW-1:0] lanes_o
);

  logic [DW-1:0] mem_q [N][N];
  logic          wr_ok;
  logic [IW-1:0] diag;

  assign wr_ok = idx_in_range(int'(row_i), N) && idx_in_range(int'(col_i), N);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the bank is a register file, not a RAM macro, so every entry clears on reset.
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (we_i && wr_ok) begin
      mem_q[row_i][col_i] <= data_i;
    end
  end

  // Lanes whose diagonal position falls outside the matrix carry +0.0 padding.
  always_comb begin
    lanes_o = '0;
    diag    = '0;
    for (int l = 0; l < N; l++) begin
      lanes_o[l*DW +: DW] = DW'(FP16_ZERO);
      if (int'(k_i) >= l && int'(k_i) - l < N) begin
        diag = IW'(int'(k_i) - l);
        lanes_o[l*DW +: DW] = COL_MAJOR ? mem_q[diag][IW'(l)] : mem_q[IW'(l)][diag];
      end
    end
  end

endmodule

// File: rtl/mmm_edge_feeder.sv
// Transmit side of the PE edge interface: streams skewed rows of A to the left edge and
// skewed columns of B to the top edge, with registered pe_we/pe_mux/busy/done controls.
module mmm_edge_feeder
  import mmm_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = FP16_W,
  localparam int IW = idx_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [IW-1:0]   wr_row,
  input  logic [IW-1:0]   wr_col,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [N*DW-1:0] left_out,
  output logic [N*DW-1:0] top_out,
  output logic            pe_we,
  output logic            pe_mux
);

  localparam int            KW     = IW + 2;
  localparam logic [KW-1:0] K_LAST = KW'(3 * N - 3);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pe_we_q, pe_we_d;
  logic            pe_mux_q, pe_mux_d;
  logic [N*DW-1:0] left_q, left_d;
  logic [N*DW-1:0] top_q, top_d;
  logic [N*DW-1:0] a_lanes, b_lanes;
  logic            in_idle;

  assign in_idle = (state_q == IDLE);

  // Banks are read at the next-cycle skew so the lane registers present k in cycle k.
  mmm_skew_bank #(.N(N), .DW(DW), .COL_MAJOR(1'b0)) u_bank_a (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_en && !wr_sel && in_idle),
    .row_i   (wr_row),
    .col_i   (wr_col),
    .data_i  (wr_data),
    .k_i     (k_d),
    .lanes_o (a_lanes)
  );

  mmm_skew_bank #(.N(N), .DW(DW), .COL_MAJOR(1'b1)) u_bank_b (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_en && wr_sel && in_idle),
    .row_i   (wr_row),
    .col_i   (wr_col),
    .data_i  (wr_data),
    .k_i     (k_d),
    .lanes_o (b_lanes)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR: begin
        state_d = STREAM;
        k_d     = '0;
      end
      STREAM: begin
        if (k_q == K_LAST) state_d = DONE;
        else               k_d     = k_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == CLEAR) || (state_d == STREAM);
    done_d   = (state_d == DONE);
    pe_we_d  = (state_d == CLEAR);
    pe_mux_d = (state_d == STREAM);
    left_d   = pe_mux_d ? a_lanes : '0;
    top_d    = pe_mux_d ? b_lanes : '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pe_we_q  <= 1'b0;
      pe_mux_q <= 1'b0;
      left_q   <= '0;
      top_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pe_we_q  <= pe_we_d;
      pe_mux_q <= pe_mux_d;
      left_q   <= left_d;
      top_q    <= top_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pe_we    = pe_we_q;
  assign pe_mux   = pe_mux_q;
  assign left_out = left_q;
  assign top_out  = top_q;

endmodule

// File: tb/tb_mmm_edge_feeder.sv
// Self-checking bench for mmm_edge_feeder: a pass-timeline model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mmm_edge_feeder;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int IW  = 2;
  localparam int TOT = 3 * N;

  logic            clk = 1'b0;
  logic            reset, wr_en, wr_sel, start;
  logic [IW-1:0]   wr_row, wr_col;
  logic [DW-1:0]   wr_data;
  logic            busy, done, pe_we, pe_mux;
  logic [N*DW-1:0] left_out, top_out;

  always #5 clk = ~clk;

  mmm_edge_feeder #(.N(N), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .left_out (left_out),
    .top_out  (top_out),
    .pe_we    (pe_we),
    .pe_mux   (pe_mux)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit model_valid = 1'b0;

  // Model: operand copies plus the position t within a pass (t=1 CLEAR cycle, t=3N done).
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  bit            active = 1'b0;
  int            t = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      active = 1'b0;
      t      = 0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ma[r][c] = '0;
          mb[r][c] = '0;
        end
      model_valid = 1'b1;
    end else if (!active) begin
      if (wr_en) begin
        if (wr_sel) mb[wr_row][wr_col] = wr_data;
        else        ma[wr_row][wr_col] = wr_data;
      end
      if (start) begin
        active = 1'b1;
        t      = 1;
      end
    end else begin
      t++;
      if (t > TOT) begin
        active = 1'b0;
        t      = 0;
      end
    end
  end

  function automatic logic [N*DW-1:0] exp_lanes(input bit is_b);
    logic [N*DW-1:0] v = '0;
    int k;
    if (!(active && t >= 2 && t <= TOT - 1)) return '0;
    k = t - 2;
    for (int l = 0; l < N; l++) begin
      int d = k - l;
      if (d >= 0 && d < N) v[l*DW +: DW] = is_b ? mb[d][l] : ma[l][d];
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      check("busy",     64'(busy),     64'(active && t < TOT));
      check("done",     64'(done),     64'(active && t == TOT));
      check("pe_we",    64'(pe_we),    64'(active && t == 1));
      check("pe_mux",   64'(pe_mux),   64'(active && t >= 2 && t <= TOT - 1));
      check("left_out", 64'(left_out), 64'(exp_lanes(1'b0)));
      check("top_out",  64'(top_out),  64'(exp_lanes(1'b1)));
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input bit sel, input int row, input int col, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = IW'(row);
    wr_col  = IW'(col);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output int at);
    at = -1;
    for (int i = 0; i < max_cycles; i++) begin
      if (done) begin
        at = cyc;
        return;
      end
      tick();
    end
    check("wait_done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int clear_cyc, d1, d2, dn, base;
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0;

    // Reset held three cycles.
    repeat (3) tick();
    check("rst_busy",   64'(busy),     64'd0);
    check("rst_done",   64'(done),     64'd0);
    check("rst_pe_we",  64'(pe_we),    64'd0);
    check("rst_pe_mux", 64'(pe_mux),   64'd0);
    check("rst_left",   64'(left_out), 64'd0);
    check("rst_top",    64'(top_out),  64'd0);
    reset = 1'b0;
    tick();

    // Basic pass with hand-computed lanes.
    wr(1'b0, 0, 0, 16'h4500);
    wr(1'b0, 1, 0, 16'h4000);
    wr(1'b0, 0, 1, 16'h3800);
    wr(1'b1, 0, 0, 16'h4400);
    pulse_start();
    clear_cyc = cyc;
    check("t2_pe_we",  64'(pe_we), 64'd1);
    check("t2_busy",   64'(busy),  64'd1);
    tick();
    check("t2_k0_left", 64'(left_out), 64'h0000_0000_0000_4500);
    check("t2_k0_top",  64'(top_out),  64'h0000_0000_0000_4400);
    tick();
    check("t2_k1_left", 64'(left_out), 64'h0000_0000_4000_3800);
    wait_done(TOT + 4, dn);
    check("t2_done_latency", 64'(dn - clear_cyc), 64'(TOT - 1));
    check("t2_done_busy",    64'(busy),           64'd0);
    tick();

    // Random fill of both banks, then a pass checked by the model.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, DW'($urandom));
        wr(1'b1, r, c, DW'($urandom));
      end
    pulse_start();
    wait_done(TOT + 4, dn);
    tick();

    // Same-cycle write and start; start during STREAM ignored; write during STREAM dropped.
    wr(1'b0, 0, 0, 16'h4500);
    base    = done_cnt;
    wr_en   = 1'b1; wr_sel = 1'b0; wr_row = 2'd3; wr_col = 2'd3; wr_data = 16'hC700;
    start   = 1'b1;
    tick();
    wr_en   = 1'b0; start = 1'b0;
    repeat (3) tick();
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wr_en   = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 16'h3C00;
    tick();
    wr_en   = 1'b0;
    repeat (2) tick();
    check("t3_k6_lane3", 64'(left_out[3*DW +: DW]), 64'hC700);
    wait_done(TOT + 4, dn);
    repeat (TOT + 4) tick();
    check("t3_one_done", 64'(done_cnt - base), 64'd1);

    // The dropped write left A[0][0] intact.
    pulse_start();
    tick();
    check("t4_k0_lane0", 64'(left_out[0 +: DW]), 64'h4500);
    wait_done(TOT + 4, dn);
    tick();

    // Reset mid-stream aborts without done and clears the banks.
    base = done_cnt;
    pulse_start();
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", 64'(busy),     64'd0);
    check("t5_left", 64'(left_out), 64'd0);
    check("t5_top",  64'(top_out),  64'd0);
    repeat (TOT + 4) tick();
    check("t5_no_done", 64'(done_cnt - base), 64'd0);
    pulse_start();
    for (int i = 0; i < TOT - 1; i++) begin
      tick();
      check("t5_zero_lanes", 64'(left_out | top_out), 64'd0);
    end
    wait_done(4, dn);
    tick();

    // start held high through DONE is re-accepted one cycle after DONE.
    start = 1'b1;
    tick();
    wait_done(TOT + 4, d1);
    tick();
    wait_done(TOT + 4, d2);
    start = 1'b0;
    check("t6_second_done", 64'(d2 - d1), 64'(TOT + 1));
    repeat (3) tick();

    // Randomised traffic; the per-cycle compare process carries the checking.
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(1, 0) == 1);
      wr_sel  = 1'($urandom);
      wr_row  = IW'($urandom);
      wr_col  = IW'($urandom);
      wr_data = DW'($urandom);
      start   = ($urandom_range(9, 0) == 0);
      reset   = ($urandom_range(79, 0) == 0);
      tick();
    end
    wr_en = 1'b0; start = 1'b0; reset = 1'b0;
    repeat (TOT + 2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
